// File: rtl/window3x3_gen.sv
// window3x3_gen: raster-to-3x3-window generator feeding Sobel and other 3x3 kernels.
// Accepts one pixel per valid cycle in raster order and emits the 3x3 neighbourhood
// ending at the current pixel, one cycle after the pixel is accepted.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   din_valid      din carries a pixel this cycle
//   din_sof        with din_valid: din is pixel (0,0) of a new frame
//   din[DW]        input pixel
//   dout_valid     dout1..dout9 hold a complete window
//   dout1..dout9   window: 1,2,3 top row (left..right); 4,5,6 middle; 7,8,9 bottom
//   dout_eof       only when WIN_EOF_EN is defined: last window of the frame
//
// Optional feature macro: WIN_EOF_EN adds the dout_eof port and its register.
module window3x3_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic          din_sof,
    input  logic [DW-1:0] din,
    output logic          dout_valid,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2,
    output logic [DW-1:0] dout3,
    output logic [DW-1:0] dout4,
    output logic [DW-1:0] dout5,
    output logic [DW-1:0] dout6,
    output logic [DW-1:0] dout7,
    output logic [DW-1:0] dout8,
    output logic [DW-1:0] dout9
`ifdef WIN_EOF_EN
    ,
    output logic          dout_eof
`endif
);

    localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // Column/row position counters
    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;

    // Line buffers: lb0 holds row-1, lb1 holds row-2, both indexed by column
    logic [DW-1:0] lb0_q [IMG_WIDTH];
    logic [DW-1:0] lb1_q [IMG_WIDTH];
    logic [DW-1:0] lb0_rd, lb1_rd;

    // Tap shift registers; index 0 is the oldest (leftmost) column
    logic [2:0][DW-1:0] top_q, top_d;
    logic [2:0][DW-1:0] mid_q, mid_d;
    logic [2:0][DW-1:0] bot_q, bot_d;

    logic valid_q, valid_d;
`ifdef WIN_EOF_EN
    logic eof_q, eof_d;
`endif

    // Next-state: position of the current pixel, counter advance, tap shift
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        valid_d = 1'b0;
`ifdef WIN_EOF_EN
        eof_d   = 1'b0;
`endif

        // sof overrides the counters so the pixel is taken as (0,0)
        col_cur = din_sof ? '0 : col_q;
        row_cur = din_sof ? '0 : row_q;

        // Asynchronous read returns the pre-write contents (read-before-write)
        lb0_rd  = lb0_q[col_cur];
        lb1_rd  = lb1_q[col_cur];

        if (din_valid) begin
            if (col_cur == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_HEIGHT - 1)) ? '0 : RW'(row_cur + RW'(1));
            end else begin
                col_d = CW'(col_cur + CW'(1));
                row_d = row_cur;
            end

            top_d = {lb1_rd, top_q[2], top_q[1]};
            mid_d = {lb0_rd, mid_q[2], mid_q[1]};
            bot_d = {din,    bot_q[2], bot_q[1]};

            // Column gating keeps all three columns inside one line
            valid_d = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
`ifdef WIN_EOF_EN
            eof_d   = (row_cur == RW'(IMG_HEIGHT - 1)) && (col_cur == CW'(IMG_WIDTH - 1));
`endif
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            valid_q <= 1'b0;
`ifdef WIN_EOF_EN
            eof_q   <= 1'b0;
`endif
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            valid_q <= valid_d;
`ifdef WIN_EOF_EN
            eof_q   <= eof_d;
`endif
        end
    end

    // Line-buffer RAM; contents survive reset
    always_ff @(posedge clk) begin
        if (din_valid && !rst) begin
            lb1_q[col_cur] <= lb0_rd;
            lb0_q[col_cur] <= din;
        end
    end

    assign dout_valid = valid_q;
    assign dout1      = top_q[0];
    assign dout2      = top_q[1];
    assign dout3      = top_q[2];
    assign dout4      = mid_q[0];
    assign dout5      = mid_q[1];
    assign dout6      = mid_q[2];
    assign dout7      = bot_q[0];
    assign dout8      = bot_q[1];
    assign dout9      = bot_q[2];
`ifdef WIN_EOF_EN
    assign dout_eof   = eof_q;
`endif

endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen: directed, table-driven bench for window3x3_gen at 4x4 frames.
// Pixel values are base + 16*row + col.
module tb_window3x3_gen;

    logic       clk;
    logic       rst;
    logic       din_valid;
    logic       din_sof;
    logic [7:0] din;
    logic       dout_valid;
    logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;
`ifdef WIN_EOF_EN
    logic       dout_eof;
`endif

    window3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din        (din),
        .dout_valid (dout_valid),
        .dout1      (d1),
        .dout2      (d2),
        .dout3      (d3),
        .dout4      (d4),
        .dout5      (d5),
        .dout6      (d6),
        .dout7      (d7),
        .dout8      (d8),
        .dout9      (d9)
`ifdef WIN_EOF_EN
        ,
        .dout_eof   (dout_eof)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dout_a [9];
    always_comb begin
        dout_a[0] = d1; dout_a[1] = d2; dout_a[2] = d3;
        dout_a[3] = d4; dout_a[4] = d5; dout_a[5] = d6;
        dout_a[6] = d7; dout_a[7] = d8; dout_a[8] = d9;
    end

    typedef struct {
        logic [7:0] din;
        int         exp_win;   // -1: no window expected; else index into win_tab
    } vec_t;

    vec_t       frame_vec [16];
    logic [7:0] win_tab [4][9];
    int         n_checks;
    int         n_fail;
    int         win_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string tag, input int idx, input logic [7:0] base);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s dout%0d", tag, k + 1), 32'(dout_a[k]), 32'(8'(win_tab[idx][k] + base)));
    endtask

    // Accept one pixel, check the result one cycle later, optionally insert an idle cycle
    task automatic push(input logic [7:0] pix, input bit sof, input int exp_win,
                        input logic [7:0] base, input bit gap);
        din_valid = 1'b1;
        din_sof   = sof;
        din       = pix;
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        check($sformatf("valid after px %0h", pix), 32'(dout_valid), 32'(exp_win >= 0));
        if (dout_valid) win_seen++;
        if (exp_win >= 0) check_win($sformatf("win px %0h", pix), exp_win, base);
`ifdef WIN_EOF_EN
        check($sformatf("eof after px %0h", pix), 32'(dout_eof), 32'(exp_win == 3));
`endif
        if (gap) begin
            // sof on an idle cycle must be ignored
            din_sof = 1'b1;
            @(posedge clk); #1;
            din_sof = 1'b0;
            check($sformatf("idle valid px %0h", pix), 32'(dout_valid), 32'd0);
            if (exp_win >= 0) check_win($sformatf("hold px %0h", pix), exp_win, base);
        end
    endtask

    task automatic run_frame(input bit sof_first, input bit gap, input logic [7:0] base,
                             input int n_pix);
        for (int i = 0; i < n_pix; i++)
            push(8'(frame_vec[i].din + base), sof_first && (i == 0), frame_vec[i].exp_win, base, gap);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 32'(dout_valid), 32'd0);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s dout%0d", tag, k + 1), 32'(dout_a[k]), 32'd0);
`ifdef WIN_EOF_EN
        check({tag, " eof"}, 32'(dout_eof), 32'd0);
`endif
    endtask

    initial begin
        int exp_map [16];
        exp_map = '{-1, -1, -1, -1,
                    -1, -1, -1, -1,
                    -1, -1,  0,  1,
                    -1, -1,  2,  3};
        for (int i = 0; i < 16; i++) begin
            frame_vec[i].din     = 8'((i / 4) * 16 + (i % 4));
            frame_vec[i].exp_win = exp_map[i];
        end
        win_tab[0] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        win_tab[1] = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
        win_tab[2] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
        win_tab[3] = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        din       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // 1: single frame, continuous
        win_seen = 0;
        run_frame(1'b1, 1'b0, 8'h00, 16);
        check("t1 window count", 32'(win_seen), 32'd4);

        // 2: same frame with idle cycle after every pixel
        win_seen = 0;
        run_frame(1'b1, 1'b1, 8'h00, 16);
        check("t2 window count", 32'(win_seen), 32'd4);

        // 3: two back-to-back frames, sof only on the first
        win_seen = 0;
        run_frame(1'b1, 1'b0, 8'h00, 16);
        run_frame(1'b0, 1'b0, 8'h00, 16);
        check("t3 window count", 32'(win_seen), 32'd8);

        // 4: partial frame to (2,0); sof lands where (2,1) would be
        win_seen = 0;
        run_frame(1'b1, 1'b0, 8'h40, 9);
        run_frame(1'b1, 1'b0, 8'h80, 16);
        check("t4 window count", 32'(win_seen), 32'd4);

        // 5: reset one cycle after pixel 0x22, then frames without sof
        run_frame(1'b1, 1'b0, 8'h00, 11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("t5 after rst");
        win_seen = 0;
        run_frame(1'b0, 1'b0, 8'h00, 16);
        check("t5 frame a count", 32'(win_seen), 32'd4);
        win_seen = 0;
        run_frame(1'b0, 1'b0, 8'h20, 16);
        check("t5 frame b count", 32'(win_seen), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
